// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory op encodings,
// response error codes, FSM states and the request legality check.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } lsu_state_e;

    // Classify a request: illegal op beats misalignment, which beats range.
    function automatic lsu_err_e lsu_check(
        input logic        wr,
        input logic [2:0]  op,
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] limit
    );
        logic legal;
        logic misaligned;
        case (op)
            OP_LB, OP_LH, OP_LW: legal = 1'b1;
            OP_LBU, OP_LHU:      legal = !wr;
            default:             legal = 1'b0;
        endcase
        misaligned = ((op == OP_LH || op == OP_LHU) && addr[0])
                   || (op == OP_LW && addr[1:0] != 2'b00);
        if (!legal)
            return ERR_ILLEGAL;
        if (misaligned)
            return ERR_MISALIGN;
        if (addr < base || {1'b0, addr} >= limit)
            return ERR_RANGE;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane steering: store byte enables and aligned store data, plus
// selection and sign/zero extension of load data from a 32-bit word.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rword,
    output logic [3:0]        byte_en,
    output logic [WORD_W-1:0] wdata_sh,
    output logic [WORD_W-1:0] rdata_ext
);

    logic [4:0] byte_shift;
    logic [4:0] half_shift;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Lane offsets within the word (little-endian).
    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        half_shift = {addr_lo[1], 4'b0000};
        byte_sel   = 8'(rword >> byte_shift);
        half_sel   = 16'(rword >> half_shift);
    end

    // Per-op mask, store alignment and load extension.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
        case (op)
            OP_LB, OP_LBU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_sh  = WORD_W'(wdata[7:0]) << byte_shift;
                rdata_ext = (op == OP_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                          : {24'h000000, byte_sel};
            end
            OP_LH, OP_LHU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = WORD_W'(wdata[15:0]) << half_shift;
                rdata_ext = (op == OP_LH) ? {{16{half_sel[15]}}, half_sel}
                                          : {16'h0000, half_sel};
            end
            OP_LW: begin
                byte_en   = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_sh  = '0;
                rdata_ext = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit over an internal word memory with a
// configurable access stall and a valid/ready request/response pair.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);

    lsu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rword;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic              accept;
    lsu_err_e          acc_err;

    logic [31:0] mem [DEPTH];

    // Ready is a pure decode of the idle state, held low while in reset.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign acc_err   = lsu_check(req_wr, req_op, req_addr, BASE_ADDR, LIMIT);
    assign idx       = IDX_W'((addr_q - BASE_ADDR) >> 2);
    assign rword     = mem[idx];

    lsu_lane_fmt u_lane_fmt (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // Transaction FSM: latch on acceptance, stall, access, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            op_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q       <= req_wr;
                        op_q       <= req_op;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= acc_err;
                        if (acc_err != ERR_OK) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    resp_rdata <= wr_q ? 32'h0000_0000 : rdata_ext;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commit at the closing edge of ACCESS; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == ACCESS && wr_q && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed model.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned WAITC = 1;
    localparam int unsigned NBYTE = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mb [NBYTE];

    typedef struct packed {
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [1:0]  err;
    } vec_t;

    load_store_unit #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: byte-addressed memory, access size from the op.
    task automatic model_op(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic [1:0] err);
        int size;
        bit sgn;
        int off;
        size = 0;
        sgn  = 1'b0;
        case (op)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b0; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: size = 0;
        endcase
        rd = 32'h0;
        if (size == 0 || (wr && (op == 3'd4 || op == 3'd5)))
            err = 2'b11;
        else if ((addr & 32'(size - 1)) != 32'h0)
            err = 2'b01;
        else if (addr < BASE || addr > BASE + 32'(NBYTE - 1))
            err = 2'b10;
        else
            err = 2'b00;
        if (err == 2'b00) begin
            off = int'(addr - BASE);
            if (wr) begin
                for (int k = 0; k < size; k++) mb[off + k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) rd[8*k +: 8] = mb[off + k];
                if (sgn && rd[8*size-1])
                    for (int b = 8*size; b < 32; b++) rd[b] = 1'b1;
            end
        end
    endtask

    // Drive one request, scramble inputs after acceptance, measure latency.
    task automatic do_req(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic [1:0] err, output int lat);
        int t;
        rd = 32'h0; err = 2'b00; lat = 0;
        req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, t);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wr = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, lat);
            return;
        end
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        rd = resp_rdata; err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_wr = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 00",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        vec_t tbl [21];
        logic [31:0] rd, mrd;
        logic [1:0]  err, merr;
        int lat, elat;
        tbl = '{
            '{1'b1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 2'b00},
            '{1'b0, 3'd2, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 2'b00},
            '{1'b0, 3'd0, 32'h8000_0003, 32'h0,         32'hFFFF_FFDE, 2'b00},
            '{1'b0, 3'd4, 32'h8000_0003, 32'h0,         32'h0000_00DE, 2'b00},
            '{1'b0, 3'd1, 32'h8000_0002, 32'h0,         32'hFFFF_DEAD, 2'b00},
            '{1'b0, 3'd5, 32'h8000_0002, 32'h0,         32'h0000_DEAD, 2'b00},
            '{1'b1, 3'd0, 32'h8000_0001, 32'h0000_0055, 32'h0000_0000, 2'b00},
            '{1'b0, 3'd2, 32'h8000_0000, 32'h0,         32'hDEAD_55EF, 2'b00},
            '{1'b0, 3'd2, 32'h8000_0002, 32'h0,         32'h0000_0000, 2'b01},
            '{1'b1, 3'd1, 32'h8000_0001, 32'h0000_1234, 32'h0000_0000, 2'b01},
            '{1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 2'b10},
            '{1'b0, 3'd3, 32'h8000_0000, 32'h0,         32'h0000_0000, 2'b11},
            '{1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11},
            '{1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11},
            '{1'b0, 3'd2, 32'h8000_0000, 32'h0,         32'hDEAD_55EF, 2'b00},
            '{1'b0, 3'd7, 32'h7FFF_FFFD, 32'h0,         32'h0000_0000, 2'b11},
            '{1'b0, 3'd2, 32'h7FFF_FFFE, 32'h0,         32'h0000_0000, 2'b01},
            '{1'b0, 3'd2, 32'h8000_1000, 32'h0,         32'h0000_0000, 2'b10},
            '{1'b1, 3'd2, 32'h8000_0FFC, 32'hA5A5_1234, 32'h0000_0000, 2'b00},
            '{1'b0, 3'd1, 32'h8000_0FFE, 32'h0,         32'hFFFF_A5A5, 2'b00},
            '{1'b0, 3'd5, 32'h8000_0FFC, 32'h0,         32'h0000_1234, 2'b00}
        };
        for (int i = 0; i < 21; i++) begin
            model_op(tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata, mrd, merr);
            do_req(tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata, 0, rd, err, lat);
            elat = (tbl[i].err != 2'b00) ? 1 : int'(WAITC) + 2;
            n_checks++;
            if (rd !== tbl[i].rd || err !== tbl[i].err) begin
                n_fail++;
                $display("FAIL directed[%0d]: rdata=%h err=%b, required rdata=%h err=%b",
                         i, rd, err, tbl[i].rd, tbl[i].err);
            end
            n_checks++;
            if (lat != elat) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: %0d edges, required %0d", i, lat, elat);
            end
        end
    endtask

    task automatic test_init_region();
        logic [31:0] rd, mrd, wd;
        logic [1:0]  err, merr;
        int lat;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_op(1'b1, 3'd2, BASE + 32'(4*i), wd, mrd, merr);
            do_req(1'b1, 3'd2, BASE + 32'(4*i), wd, 0, rd, err, lat);
            n_checks++;
            if (err !== 2'b00 || rd !== 32'h0 || lat != int'(WAITC) + 2) begin
                n_fail++;
                $display("FAIL init_store[%0d]: err=%b rdata=%h lat=%0d, required 00 00000000 %0d",
                         i, err, rd, lat, WAITC + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] mrd;
        logic [1:0]  merr;
        int t;
        model_op(1'b0, 3'd2, BASE + 32'd8, 32'h0, mrd, merr);
        req_wr = 1'b0; req_op = 3'd2; req_addr = BASE + 32'd8; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== mrd || resp_err !== 2'b00 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h 00 0",
                         c, resp_valid, resp_rdata, resp_err, req_ready, mrd);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] mrd1, mrd2;
        logic [1:0]  merr;
        int t;
        model_op(1'b0, 3'd2, BASE + 32'd12, 32'h0, mrd1, merr);
        model_op(1'b0, 3'd0, BASE + 32'd17, 32'h0, mrd2, merr);
        req_wr = 1'b0; req_op = 3'd2; req_addr = BASE + 32'd12; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 3'd0; req_addr = BASE + 32'd17;
        t = 0;
        while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (resp_rdata !== mrd1) begin
            n_fail++;
            $display("FAIL b2b_first: rdata=%h, required %h", resp_rdata, mrd1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bypass: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 1;
        while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (resp_rdata !== mrd2 || t != int'(WAITC) + 2) begin
            n_fail++;
            $display("FAIL b2b_second: rdata=%h lat=%0d, required %h %0d", resp_rdata, t, mrd2, WAITC + 2);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd;
        logic [1:0]  err, merr;
        int lat;
        for (int d = 0; d < 2; d++) begin
            req_wr = 1'b1; req_op = 3'd2; req_addr = BASE + 32'd4; req_wdata = 32'h1357_9BDF;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int k = 0; k < d; k++) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            n_checks++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_reset[%0d]: ready=%b valid=%b, required 0 0", d, req_ready, resp_valid);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_ready[%0d]: req_ready=%b, required 1", d, req_ready);
            end
            model_op(1'b0, 3'd2, BASE + 32'd4, 32'h0, mrd, merr);
            do_req(1'b0, 3'd2, BASE + 32'd4, 32'h0, 0, rd, err, lat);
            n_checks++;
            if (rd !== mrd || err !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_old_data[%0d]: rdata=%h err=%b, required %h 00", d, rd, err, mrd);
            end
        end
        req_wr = 1'b0; req_op = 3'd2; req_addr = BASE; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_in_resp: valid=%b rdata=%h err=%b, required 0 00000000 00",
                     resp_valid, resp_rdata, resp_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr, wd, rd, mrd;
        logic [1:0]  err, merr;
        int lat, elat, r;
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            wd = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0)
                addr = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            else if (r == 1)
                addr = BASE + 32'(NBYTE) + 32'($urandom_range(0, 15));
            else
                addr = BASE + 32'($urandom_range(0, 63));
            model_op(wr, op, addr, wd, mrd, merr);
            do_req(wr, op, addr, wd, int'($urandom_range(0, 2)), rd, err, lat);
            elat = (merr != 2'b00) ? 1 : int'(WAITC) + 2;
            n_checks++;
            if (rd !== mrd || err !== merr || lat != elat) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%b op=%0d addr=%h: rdata=%h err=%b lat=%0d, required %h %b %0d",
                         i, wr, op, addr, rd, err, lat, mrd, merr, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_init_region();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
